// File: rtl/player_status.sv
// Turns per-frame collision pulses into score, lives, post-hit invulnerability and game-over.
// All state and outputs are registered; blink and the state flags decode directly from registers.
module player_status #(
  parameter int COLLISION_WIDTH    = 9,
  parameter int IDX_ENEMY_MISSILE  = 0,
  parameter int IDX_PLAYER_MISSILE = 4,
  parameter int IDX_PLAYER_ENEMY   = 6,
  parameter int IDX_PLAYER_GIFT    = 7,
  parameter int START_LIVES        = 3,
  parameter int MAX_LIVES          = 7,
  parameter int LIVES_WIDTH        = 3,
  parameter int SCORE_WIDTH        = 16,
  parameter int ENEMY_POINTS       = 10,
  parameter int INVULN_FRAMES      = 60
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [COLLISION_WIDTH-1:0] HitPulse,
  input  logic                       restart,
  output logic [LIVES_WIDTH-1:0]     lives,
  output logic [SCORE_WIDTH-1:0]     score,
  output logic                       invulnerable,
  output logic                       blink,
  output logic                       player_hit,
  output logic                       game_over
);

  localparam int CNT_W = (INVULN_FRAMES < 7) ? 3 : $clog2(INVULN_FRAMES + 1);
  localparam logic [LIVES_WIDTH-1:0] START_L  = LIVES_WIDTH'(START_LIVES);
  localparam logic [LIVES_WIDTH-1:0] MAX_L    = LIVES_WIDTH'(MAX_LIVES);
  localparam logic [CNT_W-1:0]       CNT_INIT = CNT_W'(INVULN_FRAMES);
  localparam logic [SCORE_WIDTH:0]   PTS      = (SCORE_WIDTH + 1)'(ENEMY_POINTS);

  typedef enum logic [1:0] {PLAY, INVULN, GAME_OVER} state_t;

  state_t                 state, state_nxt;
  logic [LIVES_WIDTH-1:0] lives_nxt, lives_gift;
  logic [SCORE_WIDTH-1:0] score_nxt, score_sat;
  logic [SCORE_WIDTH:0]   score_sum;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   hit_nxt;
  logic                   damage, kill, gift;
  logic                   unused_hit;

  assign damage     = HitPulse[IDX_PLAYER_MISSILE] | HitPulse[IDX_PLAYER_ENEMY];
  assign kill       = HitPulse[IDX_ENEMY_MISSILE];
  assign gift       = HitPulse[IDX_PLAYER_GIFT];
  assign unused_hit = ^HitPulse;

  assign score_sum  = {1'b0, score} + PTS;
  assign score_sat  = score_sum[SCORE_WIDTH] ? '1 : score_sum[SCORE_WIDTH-1:0];
  assign lives_gift = (gift && lives < MAX_L) ? lives + 1'b1 : lives;

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    score_nxt = score;
    cnt_nxt   = cnt;
    hit_nxt   = 1'b0;
    unique case (state)
      PLAY: begin
        if (kill) score_nxt = score_sat;
        lives_nxt = lives_gift;
        // Gift is credited before damage, so a simultaneous pickup can save the last life.
        if (damage) begin
          hit_nxt = 1'b1;
          if (lives_gift > 1) begin
            lives_nxt = lives_gift - 1'b1;
            cnt_nxt   = CNT_INIT;
            state_nxt = INVULN;
          end else begin
            lives_nxt = '0;
            state_nxt = GAME_OVER;
          end
        end
      end
      INVULN: begin
        if (kill) score_nxt = score_sat;
        lives_nxt = lives_gift;
        if (startOfFrame) begin
          cnt_nxt = (cnt == '0) ? '0 : cnt - 1'b1;
          if (cnt <= 1) state_nxt = PLAY;
        end
      end
      GAME_OVER: begin
        if (restart) begin
          lives_nxt = START_L;
          score_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = PLAY;
        end
      end
      default: state_nxt = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state      <= PLAY;
      lives      <= START_L;
      score      <= '0;
      cnt        <= '0;
      player_hit <= 1'b0;
    end else begin
      state      <= state_nxt;
      lives      <= lives_nxt;
      score      <= score_nxt;
      cnt        <= cnt_nxt;
      player_hit <= hit_nxt;
    end
  end

  assign invulnerable = (state == INVULN);
  assign game_over    = (state == GAME_OVER);
  assign blink        = invulnerable & cnt[2];

endmodule

// File: tb/tb_player_status.sv
// Directed bench for player_status: damage/invulnerability timing, scoring, gifts, game over and async reset.
module tb_player_status;
  logic       clk = 1'b0;
  logic       rst;
  logic       sof;
  logic [8:0] hp;
  logic       restart;
  logic [2:0] lives;
  logic [15:0] score;
  logic       invulnerable, blink, player_hit, game_over;

  int checks = 0;
  int errors = 0;

  player_status dut (
    .clk(clk), .resetN(rst), .startOfFrame(sof), .HitPulse(hp), .restart(restart),
    .lives(lives), .score(score), .invulnerable(invulnerable), .blink(blink),
    .player_hit(player_hit), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [8:0] v);
    hp = v; step(); hp = '0;
  endtask

  task automatic frame(input logic [8:0] v);
    sof = 1'b1; hp = v; step(); sof = 1'b0; hp = '0;
  endtask

  task automatic chk_all(input string tag, input int l, input int s, input int inv,
                         input int bl, input int hit, input int go);
    chk({tag, ".lives"}, 32'(lives), l);
    chk({tag, ".score"}, 32'(score), s);
    chk({tag, ".invuln"}, 32'(invulnerable), inv);
    chk({tag, ".blink"}, 32'(blink), bl);
    chk({tag, ".hit"}, 32'(player_hit), hit);
    chk({tag, ".gameover"}, 32'(game_over), go);
  endtask

  initial begin
    rst = 1'b1; sof = 1'b0; hp = '0; restart = 1'b0;
    #2;
    chk_all("reset", 3, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    step();

    // First hit, then repeated damage inside the window; window exits on 60th frame.
    pulse(9'h010);
    chk_all("hit1", 2, 0, 1, 1, 1, 0);
    step();
    chk("hit1.hitclr", 32'(player_hit), 0);
    for (int k = 1; k <= 60; k++) begin
      if (k <= 10) begin
        pulse((k % 2) ? 9'h040 : 9'h010);
        chk("inv.ignore", 32'(lives), 2);
        chk("inv.nohit", 32'(player_hit), 0);
      end
      frame((k == 60) ? 9'h040 : 9'h000);
      chk("inv.state", 32'(invulnerable), (k < 60) ? 1 : 0);
      chk("inv.blink", 32'(blink), (k < 60) ? (((60 - k) >> 2) & 1) : 0);
    end
    chk("exit.dmgignored", 32'(lives), 2);
    chk("exit.nohit", 32'(player_hit), 0);

    // Second hit with simultaneous frame start and kill: counter must not decrement.
    frame(9'h011);
    chk_all("hit2", 1, 10, 1, 1, 1, 0);
    for (int k = 1; k <= 59; k++) frame(9'h000);
    chk("hit2.frame59", 32'(invulnerable), 1);
    frame(9'h000);
    chk("hit2.frame60", 32'(invulnerable), 0);

    // Gift and damage together at one life.
    pulse(9'h090);
    chk_all("giftdmg1", 1, 10, 1, 1, 1, 0);
    for (int k = 1; k <= 60; k++) frame(9'h000);
    chk("giftdmg1.exit", 32'(invulnerable), 0);

    // Final hit with kill ends the game, score still credited.
    pulse(9'h011);
    chk_all("hit3", 0, 20, 0, 0, 1, 1);
    pulse(9'h1FF);
    chk_all("go.frozen", 0, 20, 0, 0, 0, 1);
    restart = 1'b1; step(); restart = 1'b0;
    chk_all("restart", 3, 0, 0, 0, 0, 0);

    // Score saturation.
    for (int i = 0; i < 6553; i++) begin pulse(9'h001); step(); end
    chk("score.65530", 32'(score), 65530);
    for (int i = 0; i < 3; i++) begin pulse(9'h001); step(); end
    chk("score.sat", 32'(score), 65535);

    // Lives saturation, then gift+damage at max.
    for (int i = 0; i < 4; i++) pulse(9'h080);
    chk("gift.to7", 32'(lives), 7);
    pulse(9'h080);
    chk("gift.sat", 32'(lives), 7);
    pulse(9'h090);
    chk_all("giftdmg7", 6, 65535, 1, 1, 1, 0);
    restart = 1'b1; step(); restart = 1'b0;
    chk_all("restart.noeffect", 6, 65535, 1, 1, 0, 0);
    pulse(9'h001);
    chk("inv.killsat", 32'(score), 65535);

    // Reset, build score 120, enter INVULN, then async reset between edges.
    rst = 1'b1; step(); rst = 1'b0; step();
    chk_all("reset2", 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) pulse(9'h001);
    pulse(9'h040);
    chk_all("pre_areset", 2, 120, 1, 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk_all("areset", 3, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    chk_all("after_areset", 3, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
